// File: rtl/of_pkg.sv
// Shared widths, register-file constants and types for the operand-fetch stage.
package of_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int PC_REG    = 15;
  localparam int PC_OFFSET = 8;
  localparam int NUM_REGS  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, R15 excluded.
// Produces the read-after-write hazard for the two source operands.
module of_scoreboard #(
  parameter int ADDR_W = of_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic              use_imm,
  input  logic              mask_a,
  input  logic              mask_b,
  output logic              hazard
);
  localparam int NUM = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(of_pkg::PC_REG);

  logic [NUM-1:0] pending;
  logic [NUM-1:0] set_mask;
  logic [NUM-1:0] clr_mask;
  logic           hazard_a;
  logic           hazard_b;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_addr != PC_ADDR) set_mask[set_addr] = 1'b1;
    if (clr_en && clr_addr != PC_ADDR) clr_mask[clr_addr] = 1'b1;
  end

  // Clear applied first so a same-edge issue to the same register stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  assign hazard_a = (rn != PC_ADDR) && pending[rn] && !mask_a;
  assign hazard_b = !use_imm && (rm != PC_ADDR) && pending[rm] && !mask_b;
  assign hazard   = hazard_a | hazard_b;
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, applies PC/immediate selection, stalls on
// pending writes. Define OPERAND_FETCH_FORWARD_EN to bypass same-cycle writeback.
module operand_fetch #(
  parameter int DATA_W    = of_pkg::DATA_W,
  parameter int ADDR_W    = of_pkg::ADDR_W,
  parameter int PC_OFFSET = of_pkg::PC_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr_dest,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_dest,
  output logic [15:0]       stall_count
);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(of_pkg::PC_REG);

  logic              hazard;
  logic              accept;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] pc_val;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;

  assign rf_read_addr1 = in_rn;
  assign rf_read_addr2 = in_rm;

`ifdef OPERAND_FETCH_FORWARD_EN
  assign fwd_a = wb_wr_en && (wb_write_addr == in_rn) && (in_rn != PC_ADDR);
  assign fwd_b = wb_wr_en && (wb_write_addr == in_rm) && (in_rm != PC_ADDR);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign pc_val = in_pc + DATA_W'(PC_OFFSET);

  always_comb begin
    src_a = rf_read_data1;
    if (in_rn == PC_ADDR) src_a = pc_val;
    else if (fwd_a)       src_a = wb_write_data;
  end

  always_comb begin
    src_b = rf_read_data2;
    if (in_use_imm)            src_b = in_imm;
    else if (in_rm == PC_ADDR) src_b = pc_val;
    else if (fwd_b)            src_b = wb_write_data;
  end

  of_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (accept && in_wr_dest),
    .set_addr (in_rd),
    .clr_en   (wb_wr_en),
    .clr_addr (wb_write_addr),
    .rn       (in_rn),
    .rm       (in_rm),
    .use_imm  (in_use_imm),
    .mask_a   (fwd_a),
    .mask_b   (fwd_b),
    .hazard   (hazard)
  );

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_rd      <= '0;
      out_wr_dest <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op_a    <= src_a;
      out_op_b    <= src_b;
      out_rd      <= in_rd;
      out_wr_dest <= in_wr_dest;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             stall_count <= '0;
    else if (in_valid && hazard && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expectations follow the forwarding macro if defined.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_rn, in_rm, in_rd;
  logic        in_wr_dest, in_use_imm;
  logic [31:0] in_imm, in_pc;
  logic [3:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_wr_en;
  logic [3:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [3:0]  out_rd;
  logic        out_wr_dest;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_wr_dest(in_wr_dest), .in_use_imm(in_use_imm), .in_imm(in_imm), .in_pc(in_pc),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_wr_en(wb_wr_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd), .out_wr_dest(out_wr_dest),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0;
    in_wr_dest = 0; in_use_imm = 0; in_imm = 0; in_pc = 0;
    rf_read_data1 = 0; rf_read_data2 = 0;
    wb_wr_en = 0; wb_write_addr = 0; wb_write_data = 0; out_ready = 1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_op_a", out_op_a, 0);
    chk("rst_op_b", out_op_b, 0);
    chk("rst_stall", 32'(stall_count), 0);
    reset = 1'b0;

    // basic register read
    in_valid = 1; in_rn = 1; in_rm = 2; rf_read_data1 = 10; rf_read_data2 = 20;
    #1;
    chk("rd_addr1", 32'(rf_read_addr1), 1);
    chk("rd_addr2", 32'(rf_read_addr2), 2);
    chk("ready_idle", 32'(in_ready), 1);
    tick();
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_op_a", out_op_a, 10);
    chk("basic_op_b", out_op_b, 20);

    // PC read and immediate select, back-to-back
    in_rn = 15; in_pc = 32'h100; in_use_imm = 1; in_imm = 13; in_rm = 7; rf_read_data2 = 99;
    tick();
    chk("pc_op_a", out_op_a, 32'h108);
    chk("imm_op_b", out_op_b, 13);
    in_rm = 15; in_use_imm = 0; in_pc = 32'h200;
    tick();
    chk("pc_op_a2", out_op_a, 32'h208);
    chk("pc_op_b2", out_op_b, 32'h208);

    // RAW hazard on r3
    in_rn = 1; in_rm = 2; in_rd = 3; in_wr_dest = 1; rf_read_data1 = 10; rf_read_data2 = 20;
    tick();
    chk("issue_rd", 32'(out_rd), 3);
    chk("issue_wr_dest", 32'(out_wr_dest), 1);
    in_wr_dest = 0; in_rd = 5; in_rn = 3; rf_read_data1 = 55;
    #1;
    chk("hazard_ready", 32'(in_ready), 0);
    tick();
    chk("hazard_stall1", 32'(stall_count), 1);
    chk("hazard_drain", 32'(out_valid), 0);
    wb_wr_en = 1; wb_write_addr = 3; wb_write_data = 100;
    #1;
`ifdef OPERAND_FETCH_FORWARD_EN
    chk("fwd_ready", 32'(in_ready), 1);
    tick();
    wb_wr_en = 0;
    chk("fwd_op_a", out_op_a, 100);
    chk("fwd_stall", 32'(stall_count), 1);
`else
    chk("nofwd_ready", 32'(in_ready), 0);
    tick();
    wb_wr_en = 0; rf_read_data1 = 100;
    chk("nofwd_stall2", 32'(stall_count), 2);
    #1;
    chk("nofwd_ready_after", 32'(in_ready), 1);
    tick();
    chk("nofwd_op_a", out_op_a, 100);
`endif

    // backpressure holds outputs and does not count as a stall
    out_ready = 0; in_rn = 1; in_rm = 2; rf_read_data1 = 10; rf_read_data2 = 20;
    #1;
    chk("bp_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_hold_a", out_op_a, 100);
    end
    chk("bp_no_stall", 32'(stall_count), `ifdef OPERAND_FETCH_FORWARD_EN 1 `else 2 `endif);
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_release_a", out_op_a, 10);

    // same-edge issue and writeback to r4: set wins
    in_rd = 4; in_wr_dest = 1; wb_wr_en = 1; wb_write_addr = 4; wb_write_data = 7;
    tick();
    wb_wr_en = 0; in_wr_dest = 0; in_rd = 0;
    in_rn = 1; in_rm = 4; in_use_imm = 1;
    #1;
    chk("imm_masks_rm", 32'(in_ready), 1);
    in_use_imm = 0;
    #1;
    chk("rm_hazard", 32'(in_ready), 0);
    in_rn = 4; in_rm = 2;
    #1;
    chk("setwins_hazard", 32'(in_ready), 0);

    // reset with valid output and r3 pending
    in_rn = 1; in_rm = 2; in_rd = 3; in_wr_dest = 1;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 1);
    in_valid = 0; in_wr_dest = 0;
    #2 reset = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_rd", 32'(out_rd), 0);
    chk("async_rst_a", out_op_a, 0);
    chk("async_rst_stall", 32'(stall_count), 0);
    tick();
    reset = 0;
    in_valid = 1; in_rn = 3; in_rm = 4; rf_read_data1 = 33; rf_read_data2 = 44;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_a", out_op_a, 33);
    chk("post_rst_b", out_op_b, 44);
    chk("post_rst_stall", 32'(stall_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
